// File: rtl/huff_code_builder.sv
// ============================================================================
// Module      : huff_code_builder
// Description : Huffman code-table builder. Each accepted merge grows the tree
//               and prepends one code bit to every symbol under the merged nodes.
//               Optional HUFF_BUILD_CHK_EN adds illegal-merge detection (err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module huff_code_builder #(
  parameter int NSYM   = 10,
  parameter int CODE_W = 9,
  parameter int IDX_W  = 5,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              merge_valid,
  output logic              merge_ready,
  input  logic [IDX_W-1:0]  min1,
  input  logic [IDX_W-1:0]  min2,
  output logic [IDX_W-1:0]  new_root_index,
  output logic              busy,
  output logic              done,
  output logic              ovf,
`ifdef HUFF_BUILD_CHK_EN
  output logic              err,
`endif
  input  logic [IDX_W-1:0]  rd_sym,
  output logic [CODE_W-1:0] rd_code,
  output logic [CODE_W-1:0] rd_mask,
  output logic [LEN_W-1:0]  rd_len
);

  localparam int              c_NNODE   = 2 * NSYM - 1;
  localparam int              c_NODE_W  = $clog2(c_NNODE);
  localparam int              c_SYM_W   = $clog2(NSYM);
  localparam logic [NSYM-1:0] c_ONE     = NSYM'(1);
  localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(CODE_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NSYM-1:0]   r_tree [c_NNODE];
  logic [CODE_W-1:0] r_code [NSYM];
  logic [CODE_W-1:0] r_mask [NSYM];
  logic [LEN_W-1:0]  r_len  [NSYM];
  logic [IDX_W-1:0]  r_root;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_ovf;

  logic              w_acc;
  logic              w_legal;
  logic              w_last;
  logic [NSYM-1:0]   w_t1;
  logic [NSYM-1:0]   w_t2;
  logic              w_rd_ok;

  // start has priority over a merge presented in the same cycle
  assign w_acc  = merge_valid & (r_state == S_BUILD) & ~start;
  assign w_last = (r_cnt == IDX_W'(NSYM - 2));

  assign w_t1 = (min1 < IDX_W'(c_NNODE)) ? r_tree[min1[c_NODE_W-1:0]] : '0;
  assign w_t2 = (min2 < IDX_W'(c_NNODE)) ? r_tree[min2[c_NODE_W-1:0]] : '0;

`ifdef HUFF_BUILD_CHK_EN
  logic [c_NNODE-1:0] r_cons;
  logic               r_err;

  assign w_legal = (min1 != min2) && (min1 < r_root) && (min2 < r_root) &&
                   !r_cons[min1[c_NODE_W-1:0]] && !r_cons[min2[c_NODE_W-1:0]];
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_cons <= '0;
      r_err  <= 1'b0;
    end else if (w_acc) begin
      if (w_legal) begin
        r_cons[min1[c_NODE_W-1:0]] <= 1'b1;
        r_cons[min2[c_NODE_W-1:0]] <= 1'b1;
      end else begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_legal = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start)
      w_next = S_BUILD;
    else if (w_acc && w_legal && w_last)
      w_next = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      for (int n = 0; n < c_NNODE; n++)
        r_tree[n] <= (n < NSYM) ? (c_ONE << n) : '0;
      for (int s = 0; s < NSYM; s++) begin
        r_code[s] <= '0;
        r_mask[s] <= '0;
        r_len[s]  <= '0;
      end
      r_root <= IDX_W'(NSYM);
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_acc && w_legal) begin
      if (r_root < IDX_W'(c_NNODE))
        r_tree[r_root[c_NODE_W-1:0]] <= w_t1 | w_t2;
      r_root <= r_root + 1'b1;
      r_cnt  <= r_cnt + 1'b1;
      for (int s = 0; s < NSYM; s++) begin
        if (w_t1[s] || w_t2[s]) begin
          // a full-length symbol keeps its code; the table is flagged instead
          if (r_len[s] == c_LEN_MAX) begin
            r_ovf <= 1'b1;
          end else begin
            r_code[s] <= {~w_t1[s], r_code[s][CODE_W-1:1]};
            r_mask[s] <= {1'b1, r_mask[s][CODE_W-1:1]};
            r_len[s]  <= r_len[s] + 1'b1;
          end
        end
      end
    end
  end

  assign merge_ready    = (r_state == S_BUILD);
  assign busy           = (r_state == S_BUILD);
  assign done           = (r_state == S_DONE);
  assign ovf            = r_ovf;
  assign new_root_index = r_root;

  assign w_rd_ok = (rd_sym < IDX_W'(NSYM));
  assign rd_code = w_rd_ok ? r_code[rd_sym[c_SYM_W-1:0]] : '0;
  assign rd_mask = w_rd_ok ? r_mask[rd_sym[c_SYM_W-1:0]] : '0;
  assign rd_len  = w_rd_ok ? r_len[rd_sym[c_SYM_W-1:0]]  : '0;

endmodule

`default_nettype wire

// File: tb/tb_huff_code_builder.sv
// ============================================================================
// Module      : tb_huff_code_builder
// Description : Self-checking bench for huff_code_builder (chain builds,
//               gaps, restart, reset mid-build; err path with HUFF_BUILD_CHK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_huff_code_builder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       merge_valid;
  logic       merge_ready;
  logic [4:0] min1;
  logic [4:0] min2;
  logic [4:0] new_root_index;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [4:0] rd_sym;
  logic [8:0] rd_code;
  logic [8:0] rd_mask;
  logic [3:0] rd_len;
`ifdef HUFF_BUILD_CHK_EN
  logic       err;
`endif

  huff_code_builder #(.NSYM(10), .CODE_W(9), .IDX_W(5), .LEN_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .merge_valid    (merge_valid),
    .merge_ready    (merge_ready),
    .min1           (min1),
    .min2           (min2),
    .new_root_index (new_root_index),
    .busy           (busy),
    .done           (done),
    .ovf            (ovf),
`ifdef HUFF_BUILD_CHK_EN
    .err            (err),
`endif
    .rd_sym         (rd_sym),
    .rd_code        (rd_code),
    .rd_mask        (rd_mask),
    .rd_len         (rd_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sym;
    logic [8:0] code;
    logic [8:0] mask;
    logic [3:0] len;
  } vec_t;

  vec_t       tbl [12];
  logic [4:0] sb_q [$];
  int         exp_root;
  int         n_pass = 0;
  int         n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_root = 10;
    chk("busy_after_start", busy, 1);
    chk("root_after_start", new_root_index, 10);
  endtask

  // drive one merge; expected root goes to the scoreboard and is checked after the edge
  task automatic do_merge(input logic [4:0] a, input logic [4:0] b, input int gap, input bit legal);
    min1 = a;
    min2 = b;
    merge_valid = 1'b1;
    chk("merge_ready", merge_ready, 1);
    if (legal) exp_root++;
    sb_q.push_back(5'(exp_root));
    tick();
    merge_valid = 1'b0;
    chk("root_after_accept", new_root_index, sb_q.pop_front());
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("root_during_gap", new_root_index, exp_root);
    end
  endtask

  task automatic run_chain(input int n, input int gap);
    for (int i = 1; i <= n; i++) begin
      do_merge((i == 1) ? 5'd0 : 5'(8 + i), 5'(i), gap, 1'b1);
      if (i == 8) chk("done_before_last", done, 0);
    end
  endtask

  task automatic check_table();
    for (int k = 0; k < 12; k++) begin
      rd_sym = tbl[k].sym;
      #1;
      chk($sformatf("code_sym%0d", tbl[k].sym), rd_code, tbl[k].code);
      chk($sformatf("mask_sym%0d", tbl[k].sym), rd_mask, tbl[k].mask);
      chk($sformatf("len_sym%0d",  tbl[k].sym), rd_len,  tbl[k].len);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_root", new_root_index, 10);
    chk("rst_done", done, 0);
    chk("rst_ready", merge_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    for (int s = 0; s < 10; s++) begin
      rd_sym = 5'(s);
      #1;
      chk($sformatf("rst_len_sym%0d", s), rd_len, 0);
      chk($sformatf("rst_code_sym%0d", s), rd_code, 0);
    end
  endtask

  initial begin
    // chain tree: sym0 is all-zero depth 9; sym k>=1 is one '1' after zeros, length 10-k (sym1: 9)
    for (int k = 0; k < 10; k++) begin
      int l;
      l = (k <= 1) ? 9 : 10 - k;
      tbl[k].sym  = 5'(k);
      tbl[k].len  = 4'(l);
      tbl[k].code = (k == 0) ? 9'h000 : 9'(1 << (k - 1));
      tbl[k].mask = 9'(((1 << l) - 1) << (9 - l));
    end
    tbl[10] = '{sym: 5'd10, code: 9'h0, mask: 9'h0, len: 4'd0};
    tbl[11] = '{sym: 5'd31, code: 9'h0, mask: 9'h0, len: 4'd0};

    rst_n = 1'b0; start = 1'b0; merge_valid = 1'b0;
    min1 = '0; min2 = '0; rd_sym = '0; exp_root = 10;
    tick();
    rst_n = 1'b1;
    check_reset_outputs();

    // back-to-back chain
    start_pulse();
    run_chain(9, 0);
    chk("done_after_last", done, 1);
    chk("busy_after_last", busy, 0);
    chk("ready_after_last", merge_ready, 0);
    check_table();
    chk("ovf_chain", ovf, 0);

    // done holds; merges presented in DONE are not accepted
    merge_valid = 1'b1; min1 = 5'd0; min2 = 5'd1;
    tick(); tick();
    merge_valid = 1'b0;
    chk("done_hold", done, 1);
    chk("root_hold_in_done", new_root_index, 19);

    // gapped chain
    start_pulse();
    chk("done_cleared_by_start", done, 0);
    run_chain(9, 3);
    chk("done_gapped", done, 1);
    check_table();

    // restart after 4 merges, then a full chain
    start_pulse();
    run_chain(4, 0);
    start_pulse();
    rd_sym = 5'd0;
    #1;
    chk("len_after_restart", rd_len, 0);
    run_chain(9, 0);
    chk("done_restart", done, 1);
    check_table();
    chk("ovf_restart", ovf, 0);

    // start beats a same-cycle merge
    start_pulse();
    run_chain(2, 0);
    min1 = 5'd11; min2 = 5'd3; merge_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; merge_valid = 1'b0; exp_root = 10;
    chk("start_beats_merge_root", new_root_index, 10);
    chk("start_beats_merge_busy", busy, 1);

    // reset mid-build after 5 merges
    run_chain(5, 0);
    rst_n = 1'b0;
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset_ready", merge_ready, 0);

`ifdef HUFF_BUILD_CHK_EN
    start_pulse();
    chk("err_clear", err, 0);
    do_merge(5'd3, 5'd3, 0, 1'b0);
    chk("err_same_idx", err, 1);
    do_merge(5'd0, 5'd15, 0, 1'b0);
    chk("err_sticky", err, 1);
    chk("root_unchanged_illegal", new_root_index, 10);
    rd_sym = 5'd3;
    #1;
    chk("len_sym3_illegal", rd_len, 0);
    do_merge(5'd0, 5'd1, 0, 1'b1);
    do_merge(5'd0, 5'd2, 0, 1'b0);
    chk("root_consumed_illegal", new_root_index, 11);
    start_pulse();
    chk("err_cleared_by_start", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
